// File: rtl/demux_pkg.sv
// Shared widths, FSM state codes and default bus timing for the demux chip blocks.
// The timing defaults are also used by the channel stepper.
package demux_pkg;

  localparam int CH_W = 5;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t SETUP = 3'd1;
  localparam state_t PULSE = 3'd2;
  localparam state_t HOLD  = 3'd3;
  localparam state_t GAP   = 3'd4;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_HOLD_CYC  = 2;
  localparam int DEF_GAP_CYC   = 2;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/demux_cycle_timer.sv
// Loadable down-counter that stops at zero. Its zero flag reflects the current count, and a load takes effect on the next cycle.
// Nothing upstream can stall it: it obeys load every cycle.
module demux_cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  // Holding at zero keeps the maximum load value from wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/demux_write_ctrl.sv
// Write-cycle engine for the demux chip. cs rises 1 cycle after accept, and the period is SETUP+PULSE+HOLD+GAP+1.
// req_ready is high only in IDLE, so a request held high during a write waits for the first idle cycle.
module demux_write_ctrl
  import demux_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter bit BBM       = 1'b1,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CH_W-1:0] req_ch,
  input  logic            req_ena,
  output logic            ena,
  output logic            wr,
  output logic            cs,
  output logic [CH_W-1:0] set_ch,
  output logic            busy,
  output logic            done
);

  if (SETUP_CYC < 1 || SETUP_CYC >= 2**CNT_W ||
      PULSE_CYC < 1 || PULSE_CYC >= 2**CNT_W ||
      HOLD_CYC  < 1 || HOLD_CYC  >= 2**CNT_W ||
      GAP_CYC   < 0 || GAP_CYC   >= 2**CNT_W) begin : g_bad_timing
    $error("demux_write_ctrl: timing parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  state_t           state;
  logic             ena_lat;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // The timer is reloaded on the same edge that enters each timed state.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE:  if (req_valid) begin load = 1'b1; load_val = SETUP_LD; end
      SETUP: if (zero) begin load = 1'b1; load_val = PULSE_LD; end
      PULSE: if (zero) begin load = 1'b1; load_val = HOLD_LD; end
      HOLD:  if (zero && GAP_CYC > 0) begin load = 1'b1; load_val = GAP_LD; end
      default: ;
    endcase
  end

  demux_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ena     <= 1'b0;
      wr      <= 1'b0;
      cs      <= 1'b0;
      set_ch  <= '0;
      done    <= 1'b0;
      ena_lat <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            set_ch  <= req_ch;
            cs      <= 1'b1;
            ena_lat <= req_ena;
            if (BBM) ena <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (zero) begin
            wr    <= 1'b1;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (zero) begin
            wr    <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (zero) begin
            cs    <= 1'b0;
            ena   <= ena_lat;
            done  <= 1'b1;
            state <= (GAP_CYC > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (zero) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_write_ctrl.sv
// Four timing configurations share one random request stream. Each is checked every cycle
// against a model that derives the expected waveforms from the cycle offset since accept.
module tb_demux_write_ctrl;

  localparam int N = 4;

  int  cfg_s   [N] = '{2, 2, 1, 7};
  int  cfg_p   [N] = '{4, 4, 1, 7};
  int  cfg_h   [N] = '{2, 2, 1, 7};
  int  cfg_g   [N] = '{2, 2, 0, 7};
  bit  cfg_bbm [N] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ena;
  logic [4:0] req_ch;

  logic       ready_o [N];
  logic       ena_o   [N];
  logic       wr_o    [N];
  logic       cs_o    [N];
  logic       busy_o  [N];
  logic       done_o  [N];
  logic [4:0] ch_o    [N];

  bit         m_act  [N];
  int         m_k    [N];
  logic [4:0] m_ch   [N];
  bit         m_ena  [N];
  bit         m_lat  [N];
  bit         m_done [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_write_ctrl u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[0]),
    .req_ch(req_ch), .req_ena(req_ena), .ena(ena_o[0]), .wr(wr_o[0]),
    .cs(cs_o[0]), .set_ch(ch_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  demux_write_ctrl #(.BBM(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[1]),
    .req_ch(req_ch), .req_ena(req_ena), .ena(ena_o[1]), .wr(wr_o[1]),
    .cs(cs_o[1]), .set_ch(ch_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  demux_write_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .GAP_CYC(0), .BBM(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[2]),
    .req_ch(req_ch), .req_ena(req_ena), .ena(ena_o[2]), .wr(wr_o[2]),
    .cs(cs_o[2]), .set_ch(ch_o[2]), .busy(busy_o[2]), .done(done_o[2])
  );

  demux_write_ctrl #(.SETUP_CYC(7), .PULSE_CYC(7), .HOLD_CYC(7), .GAP_CYC(7), .BBM(1'b0), .CNT_W(3)) u_dut_d (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_o[3]),
    .req_ch(req_ch), .req_ena(req_ena), .ena(ena_o[3]), .wr(wr_o[3]),
    .cs(cs_o[3]), .set_ch(ch_o[3]), .busy(busy_o[3]), .done(done_o[3])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    bit         p_rst;
    bit         p_val;
    bit         p_ena;
    logic [4:0] p_ch;
    int         tw;
    bit         e_cs;
    bit         e_wr;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_ch    = 5'd0;
    req_ena   = 1'b0;
    p_rst = 1'b1; p_val = 1'b0; p_ena = 1'b0; p_ch = 5'd0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_ch[i] = 5'd0; m_ena[i] = 1'b0; m_lat[i] = 1'b0; m_done[i] = 1'b0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        tw = cfg_s[i] + cfg_p[i] + cfg_h[i];
        m_done[i] = 1'b0;
        if (p_rst) begin
          m_act[i] = 1'b0; m_k[i] = 0; m_ch[i] = 5'd0; m_ena[i] = 1'b0;
        end else if (m_act[i]) begin
          m_k[i]++;
          if (m_k[i] == tw + 1) begin
            m_done[i] = 1'b1;
            m_ena[i]  = m_lat[i];
          end
          if (m_k[i] == tw + cfg_g[i] + 1) m_act[i] = 1'b0;
        end else if (p_val) begin
          m_act[i] = 1'b1;
          m_k[i]   = 1;
          m_ch[i]  = p_ch;
          m_lat[i] = p_ena;
          if (cfg_bbm[i]) m_ena[i] = 1'b0;
        end
        e_cs = m_act[i] && m_k[i] <= tw;
        e_wr = m_act[i] && m_k[i] >= cfg_s[i] + 1 && m_k[i] <= cfg_s[i] + cfg_p[i];
        check_val($sformatf("cs[%0d]", i),     32'(cs_o[i]),    32'(e_cs));
        check_val($sformatf("wr[%0d]", i),     32'(wr_o[i]),    32'(e_wr));
        check_val($sformatf("done[%0d]", i),   32'(done_o[i]),  32'(m_done[i]));
        check_val($sformatf("busy[%0d]", i),   32'(busy_o[i]),  32'(m_act[i]));
        check_val($sformatf("ready[%0d]", i),  32'(ready_o[i]), 32'(!m_act[i]));
        check_val($sformatf("ena[%0d]", i),    32'(ena_o[i]),   32'(m_ena[i]));
        check_val($sformatf("set_ch[%0d]", i), 32'(ch_o[i]),    32'(m_ch[i]));
      end

      rst       = (cyc < 3) ? 1'b1 : ($urandom_range(0, 79) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_ch    = 5'($urandom_range(0, 31));
      req_ena   = ($urandom_range(0, 2) != 0);
      p_rst = rst; p_val = req_valid; p_ena = req_ena; p_ch = req_ch;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
